nfc_apb_regs: RTL and testbench

APB slave register front-end for the NAND flash controller. It takes software writes on the APB bus and fills a command byte queue and an address byte queue, and it holds the transfer length. On a GO request it streams the queued bytes, with a valid/ready handshake, into the downstream flash-cycle FSM, then waits for that FSM to report completion. It sits directly upstream of the FSM and is the only path from the CPU to the flash.

---
 rtl/nfc_apb_regs_pkg.sv | 32 +++
 rtl/nfc_apb_regs_if.sv | 32 +++
 rtl/nfc_byte_fifo.sv | 64 ++++++
 rtl/nfc_apb_regs.sv | 154 +++++++++++++++
 tb/tb_nfc_apb_regs.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nfc_apb_regs_pkg.sv
// Shared definitions for the NAND flash controller APB register front-end:
// register offsets, STAT/CTRL bit positions and sequencer state encodings.
package nfc_apb_regs_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Word offsets (PADDR[4:2])
  localparam logic [2:0] OFF_CMD  = 3'd0;
  localparam logic [2:0] OFF_ADDR = 3'd1;
  localparam logic [2:0] OFF_LEN  = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;

  localparam int CTRL_GO  = 0;
  localparam int CTRL_CLR = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_CMD_FULL  = 2;
  localparam int STAT_ADDR_FULL = 3;
  localparam int STAT_ERR       = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_ADDR = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT      = 3'd4
  } state_e;

endpackage

// File: rtl/nfc_apb_regs_if.sv
// APB slave bus plus the byte-stream handshake towards the flash-cycle FSM.
interface nfc_apb_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  C_Cmd;
  logic        C_CmdVld;
  logic [7:0]  C_Addr;
  logic        C_AddrVld;
  logic [7:0]  C_Length;
  logic        C_Start;
  logic        C_Ready;
  logic        C_Done;
  logic [7:0]  C_Status;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, C_Ready, C_Done, C_Status,
    output PRDATA, PREADY, PSLVERR, C_Cmd, C_CmdVld, C_Addr, C_AddrVld,
           C_Length, C_Start
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, C_Ready, C_Done, C_Status,
    input  PRDATA, PREADY, PSLVERR, C_Cmd, C_CmdVld, C_Addr, C_AddrVld,
           C_Length, C_Start
  );
endinterface

// File: rtl/nfc_byte_fifo.sv
// Small byte queue with flush; head is presented combinationally so the
// sequencer can hold it on the handshake while waiting for ready.
module nfc_byte_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/nfc_apb_regs.sv
// APB register front-end: queues command/address bytes from software and
// streams them to the flash-cycle FSM on GO, then waits for its completion.
module nfc_apb_regs
  import nfc_apb_regs_pkg::*;
#(
  parameter int CMD_DEPTH  = 2,
  parameter int ADDR_DEPTH = 5
) (
  input logic          PCLK,
  input logic          PRESETN,
  nfc_apb_regs_if.slave bus
);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int ACW = $clog2(ADDR_DEPTH + 1);

  state_e         state_q, state_d;
  logic [7:0]     len_q, len_d, status_q, status_d;
  logic           done_q, done_d, err_q, err_d;
  logic [CCW-1:0] cmd_cnt;
  logic [ACW-1:0] addr_cnt;
  logic           cmd_full, cmd_empty, addr_full, addr_empty;
  logic [7:0]     cmd_head, addr_head;
  logic           cmd_push, addr_push, cmd_pop, addr_pop, q_flush;
  logic [2:0]     off;
  logic           busy, wr_en, wr_err, wr_ok, go_req, clr_req;
  logic           go_accept, stat_w1c, len_we, done_set;
  logic           cmd_vld, addr_vld, start;
  logic [31:0]    rdata;
  logic           unused_bits;

  assign off     = bus.PADDR[4:2];
  assign busy    = (state_q != ST_IDLE);
  assign wr_en   = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign clr_req = bus.PWDATA[CTRL_CLR];
  assign go_req  = bus.PWDATA[CTRL_GO] & ~clr_req;

  // Errored writes have no side effect other than setting ERR.
  always_comb begin
    wr_err = 1'b0;
    case (off)
      OFF_CMD:  wr_err = busy | cmd_full;
      OFF_ADDR: wr_err = busy | addr_full;
      OFF_LEN:  wr_err = busy;
      OFF_CTRL: wr_err = busy | (go_req & cmd_empty);
      OFF_STAT: wr_err = 1'b0;
      default:  wr_err = 1'b1;
    endcase
  end

  assign wr_ok     = wr_en & ~wr_err;
  assign cmd_push  = wr_ok & (off == OFF_CMD);
  assign addr_push = wr_ok & (off == OFF_ADDR);
  assign len_we    = wr_ok & (off == OFF_LEN);
  assign q_flush   = wr_ok & (off == OFF_CTRL) & clr_req;
  assign go_accept = wr_ok & (off == OFF_CTRL) & go_req;
  assign stat_w1c  = wr_ok & (off == OFF_STAT);

  nfc_byte_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(PCLK), .rst_n(PRESETN), .push_i(cmd_push), .pop_i(cmd_pop),
    .flush_i(q_flush), .data_i(bus.PWDATA[7:0]), .data_o(cmd_head),
    .count_o(cmd_cnt), .full_o(cmd_full), .empty_o(cmd_empty)
  );

  nfc_byte_fifo #(.DEPTH(ADDR_DEPTH)) u_addr_fifo (
    .clk(PCLK), .rst_n(PRESETN), .push_i(addr_push), .pop_i(addr_pop),
    .flush_i(q_flush), .data_i(bus.PWDATA[7:0]), .data_o(addr_head),
    .count_o(addr_cnt), .full_o(addr_full), .empty_o(addr_empty)
  );

  always_comb begin
    state_d  = state_q;
    cmd_vld  = 1'b0;
    addr_vld = 1'b0;
    cmd_pop  = 1'b0;
    addr_pop = 1'b0;
    start    = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: if (go_accept) state_d = ST_SEND_CMD;
      ST_SEND_CMD: begin
        cmd_vld = 1'b1;
        if (bus.C_Ready) begin
          cmd_pop = 1'b1;
          if (cmd_cnt == CCW'(1)) state_d = addr_empty ? ST_START : ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        addr_vld = 1'b1;
        if (bus.C_Ready) begin
          addr_pop = 1'b1;
          if (addr_cnt == ACW'(1)) state_d = ST_START;
        end
      end
      ST_START: begin
        start   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (bus.C_Done) begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hardware set beats a same-cycle software W1C clear.
  always_comb begin
    len_d    = len_we ? bus.PWDATA[7:0] : len_q;
    done_d   = (done_q & ~(stat_w1c & bus.PWDATA[STAT_DONE])) | done_set;
    err_d    = (err_q & ~(stat_w1c & bus.PWDATA[STAT_ERR])) | (wr_en & wr_err);
    status_d = done_set ? bus.C_Status : status_q;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.PSEL && PRESETN) begin
      case (off)
        OFF_CMD:  rdata = 32'(cmd_cnt);
        OFF_ADDR: rdata = 32'(addr_cnt);
        OFF_LEN:  rdata = {24'h0, len_q};
        OFF_STAT: rdata = {16'h0, status_q, 3'b000, err_q, addr_full, cmd_full, done_q, busy};
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.PRDATA    = rdata;
  assign bus.PREADY    = HIGH;
  assign bus.PSLVERR   = PRESETN & bus.PSEL & bus.PENABLE &
                         (bus.PWRITE ? wr_err : (off > OFF_STAT));
  assign bus.C_Cmd     = cmd_vld ? cmd_head : 8'h00;
  assign bus.C_CmdVld  = cmd_vld;
  assign bus.C_Addr    = addr_vld ? addr_head : 8'h00;
  assign bus.C_AddrVld = addr_vld;
  assign bus.C_Length  = len_q;
  assign bus.C_Start   = start;
  assign unused_bits   = &{1'b0, bus.PWDATA[31:8], bus.PADDR[1:0]};
endmodule

// File: tb/tb_nfc_apb_regs.sv
// Scoreboard bench: stimulus queues expected APB responses and flash-side
// bytes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_nfc_apb_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nfc_apb_regs_if bus();
  nfc_apb_regs #(.CMD_DEPTH(2), .ADDR_DEPTH(5)) dut (
    .PCLK(clk), .PRESETN(rst_n), .bus(bus)
  );

  localparam logic [4:0] A_CMD = 5'h00, A_ADDR = 5'h04, A_LEN = 5'h08;
  localparam logic [4:0] A_CTRL = 5'h0C, A_STAT = 5'h10, A_BAD = 5'h14, A_BAD2 = 5'h1C;

  typedef struct packed {
    logic        is_rd;
    logic        err;
    logic [4:0]  addr;
    logic [31:0] rdata;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] cmd_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] start_q[$];
  apb_exp_t   mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  int         start_cnt = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err);
    apb_q.push_back('{is_rd: !wr, err: exp_err, addr: a, rdata: exp_rd});
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input logic exp_err);
    apb_xfer(1'b1, a, d, 32'h0, exp_err);
  endtask

  task automatic apb_read(input logic [4:0] a, input logic [31:0] exp_rd, input logic exp_err);
    apb_xfer(1'b0, a, 32'h0, exp_rd, exp_err);
  endtask

  task automatic pulse_done(input logic [7:0] st);
    @(posedge clk); #1;
    bus.C_Done = 1'b1; bus.C_Status = st;
    @(posedge clk); #1;
    bus.C_Done = 1'b0; bus.C_Status = 8'h00;
  endtask

  task automatic wait_start(input int target);
    for (int i = 0; i < 100 && start_cnt < target; i++) @(negedge clk);
    chk("start_seen", start_cnt, target);
  endtask

  task automatic wait_addr_accept(output logic found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.C_AddrVld && bus.C_Ready) found = 1'b1;
    end
  endtask

  // Monitor: APB responses, flash-side bytes, start pulses, hold/exclusion rules.
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (apb_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL apb_unexpected: got access to %h, expected none", bus.PADDR);
      end else begin
        mon_e = apb_q.pop_front();
        chk($sformatf("pslverr@%h", mon_e.addr), 32'(bus.PSLVERR), 32'(mon_e.err));
        chk("pready", 32'(bus.PREADY), 32'h1);
        if (mon_e.is_rd) chk($sformatf("prdata@%h", mon_e.addr), bus.PRDATA, mon_e.rdata);
      end
    end
    if (bus.C_CmdVld || bus.C_AddrVld)
      chk("vld_exclusive", 32'(bus.C_CmdVld & bus.C_AddrVld), 32'h0);
    if (stall_pend)
      chk("addr_hold", {23'h0, bus.C_AddrVld, bus.C_Addr}, {23'h0, 1'b1, stall_byte});
    stall_pend = bus.C_AddrVld && !bus.C_Ready;
    stall_byte = bus.C_Addr;
    if (bus.C_CmdVld && bus.C_Ready) begin
      if (cmd_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL cmd_unexpected: got byte %h, expected none", bus.C_Cmd);
      end else chk("c_cmd", 32'(bus.C_Cmd), 32'(cmd_q.pop_front()));
    end
    if (bus.C_AddrVld && bus.C_Ready) begin
      if (addr_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL addr_unexpected: got byte %h, expected none", bus.C_Addr);
      end else chk("c_addr", 32'(bus.C_Addr), 32'(addr_q.pop_front()));
    end
    if (bus.C_Start) begin
      start_cnt++;
      if (start_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL start_unexpected: got C_Start, expected none");
      end else chk("c_length@start", 32'(bus.C_Length), 32'(start_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    bus.C_Ready = 1'b1; bus.C_Done = 1'b0; bus.C_Status = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {5'h0, bus.C_CmdVld, bus.C_AddrVld, bus.C_Start,
        bus.C_Cmd, bus.C_Addr, bus.C_Length}, 32'h0);
    chk("reset_prdata_pslverr", bus.PRDATA | 32'(bus.PSLVERR), 32'h0);
    rst_n = 1'b1;
    apb_read(A_STAT, 32'h0, 1'b0);
    apb_read(A_CMD, 32'h0, 1'b0);

    // Main load-and-go: 00h, 5 address bytes, 30h, LEN 10h
    apb_write(A_CMD, 32'h00, 1'b0);
    for (int a = 1; a <= 5; a++) apb_write(A_ADDR, 32'(a), 1'b0);
    apb_write(A_CMD, 32'h30, 1'b0);
    apb_write(A_LEN, 32'h10, 1'b0);
    apb_read(A_CMD, 32'h2, 1'b0);
    apb_read(A_ADDR, 32'h5, 1'b0);
    apb_read(A_LEN, 32'h10, 1'b0);
    apb_read(A_STAT, 32'h0000_000C, 1'b0);
    apb_write(A_CMD, 32'h77, 1'b1);
    apb_write(A_ADDR, 32'h66, 1'b1);
    apb_read(A_CMD, 32'h2, 1'b0);
    apb_read(A_STAT, 32'h0000_001C, 1'b0);
    apb_write(A_STAT, 32'h10, 1'b0);
    apb_read(A_STAT, 32'h0000_000C, 1'b0);
    apb_read(A_BAD, 32'h0, 1'b1);
    apb_write(A_BAD2, 32'h1, 1'b1);
    apb_write(A_STAT, 32'h10, 1'b0);

    cmd_q.push_back(8'h00); cmd_q.push_back(8'h30);
    for (int a = 1; a <= 5; a++) addr_q.push_back(8'(a));
    start_q.push_back(8'h10);
    apb_write(A_CTRL, 32'h1, 1'b0);
    chk("go_latency", 32'(bus.C_CmdVld), 32'h1);
    wait_start(1);
    apb_read(A_STAT, 32'h0000_0001, 1'b0);
    apb_write(A_CMD, 32'h12, 1'b1);
    apb_write(A_LEN, 32'h34, 1'b1);
    apb_read(A_STAT, 32'h0000_0011, 1'b0);
    apb_write(A_STAT, 32'h10, 1'b0);
    pulse_done(8'hE0);
    apb_read(A_STAT, 32'h0000_E002, 1'b0);
    apb_write(A_STAT, 32'h2, 1'b0);
    apb_read(A_STAT, 32'h0000_E000, 1'b0);
    pulse_done(8'h55);
    apb_read(A_STAT, 32'h0000_E000, 1'b0);
    apb_read(A_LEN, 32'h10, 1'b0);

    // GO with an empty command queue must be refused
    apb_write(A_CTRL, 32'h1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_cmdvld", 32'(bus.C_CmdVld), 32'h0);
    end
    apb_read(A_STAT, 32'h0000_E010, 1'b0);
    apb_write(A_STAT, 32'h10, 1'b0);

    // CLR together with GO: flush wins, nothing is sent
    apb_write(A_CMD, 32'hAA, 1'b0);
    apb_write(A_ADDR, 32'hBB, 1'b0);
    apb_write(A_CTRL, 32'h3, 1'b0);
    apb_read(A_CMD, 32'h0, 1'b0);
    apb_read(A_ADDR, 32'h0, 1'b0);
    apb_read(A_STAT, 32'h0000_E000, 1'b0);

    // Ready held low for 4 cycles after the first address byte
    apb_write(A_CMD, 32'h80, 1'b0);
    apb_write(A_ADDR, 32'h11, 1'b0);
    apb_write(A_ADDR, 32'h22, 1'b0);
    apb_write(A_ADDR, 32'h33, 1'b0);
    apb_write(A_LEN, 32'h04, 1'b0);
    cmd_q.push_back(8'h80);
    addr_q.push_back(8'h11); addr_q.push_back(8'h22); addr_q.push_back(8'h33);
    start_q.push_back(8'h04);
    apb_write(A_CTRL, 32'h1, 1'b0);
    chk("go_latency2", 32'(bus.C_CmdVld), 32'h1);
    wait_addr_accept(found);
    chk("addr_reached", 32'(found), 32'h1);
    @(posedge clk); #1;
    bus.C_Ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.C_Ready = 1'b1;
    wait_start(2);
    pulse_done(8'h40);
    apb_read(A_STAT, 32'h0000_4002, 1'b0);

    // Reset in the middle of the address phase
    apb_write(A_CMD, 32'h90, 1'b0);
    for (int a = 1; a <= 5; a++) apb_write(A_ADDR, 32'(a), 1'b0);
    apb_write(A_LEN, 32'h08, 1'b0);
    cmd_q.push_back(8'h90);
    addr_q.push_back(8'h01);
    apb_write(A_CTRL, 32'h1, 1'b0);
    wait_addr_accept(found);
    chk("addr_reached2", 32'(found), 32'h1);
    @(posedge clk); #1;
    bus.C_Ready = 1'b0;
    rst_n = 1'b0;
    bus.PSEL = 1'b1; bus.PADDR = A_STAT;
    #1;
    chk("midrst_outputs", {5'h0, bus.C_CmdVld, bus.C_AddrVld, bus.C_Start,
        bus.C_Cmd, bus.C_Addr, bus.C_Length}, 32'h0);
    chk("midrst_prdata_pslverr", bus.PRDATA | 32'(bus.PSLVERR), 32'h0);
    bus.PSEL = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.C_Ready = 1'b1;
    apb_read(A_STAT, 32'h0, 1'b0);
    apb_read(A_CMD, 32'h0, 1'b0);
    apb_read(A_ADDR, 32'h0, 1'b0);
    apb_read(A_LEN, 32'h0, 1'b0);

    // Fresh operation after reset: command only, no address bytes
    apb_write(A_CMD, 32'hFF, 1'b0);
    apb_write(A_LEN, 32'h01, 1'b0);
    cmd_q.push_back(8'hFF);
    start_q.push_back(8'h01);
    apb_write(A_CTRL, 32'h1, 1'b0);
    wait_start(3);
    pulse_done(8'hC0);
    apb_read(A_STAT, 32'h0000_C002, 1'b0);

    repeat (3) @(posedge clk);
    chk("cmd_q_left", 32'(cmd_q.size()), 32'h0);
    chk("addr_q_left", 32'(addr_q.size()), 32'h0);
    chk("start_q_left", 32'(start_q.size()), 32'h0);
    chk("apb_q_left", 32'(apb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
